// File: rtl/cmd_stream_encoder.sv
// Serializes rasterizer command requests into 32-bit AXI-Stream command words.
// Optional macro CMD_ENCODER_TEX16_PACK_EN: 16-bit payload input, two beats packed per word.
module cmd_stream_encoder #(
    parameter int CMD_STREAM_WIDTH = 32,
    parameter int COUNTER_WIDTH    = 16
) (
    input  logic                        aclk,
    input  logic                        reset,
    input  logic                        s_req_valid,
    output logic                        s_req_ready,
    input  logic [3:0]                  s_req_op,
    input  logic [27:0]                 s_req_imm,
    input  logic [15:0]                 s_req_cfg_data,
    input  logic                        s_payload_axis_tvalid,
    output logic                        s_payload_axis_tready,
`ifdef CMD_ENCODER_TEX16_PACK_EN
    input  logic [15:0]                 s_payload_axis_tdata,
`else
    input  logic [31:0]                 s_payload_axis_tdata,
`endif
    output logic                        m_cmd_axis_tvalid,
    input  logic                        m_cmd_axis_tready,
    output logic                        m_cmd_axis_tlast,
    output logic [CMD_STREAM_WIDTH-1:0] m_cmd_axis_tdata,
    output logic                        busy,
    output logic                        err_bad_op,
    output logic [2:0]                  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CONFIG  = 3'd3
    } state_t;

    localparam logic [3:0] OP_NOP       = 4'd0;
    localparam logic [3:0] OP_TEXTURE   = 4'd1;
    localparam logic [3:0] OP_RENDER    = 4'd2;
    localparam logic [3:0] OP_TRIANGLE  = 4'd4;

    state_t                     state_q;
    logic [3:0]                 op_q;
    logic [27:0]                imm_q;
    logic [15:0]                cfg_q;
    logic [COUNTER_WIDTH-1:0]   load_cnt_q;
    logic [COUNTER_WIDTH-1:0]   word_cnt_d;
    logic                       tvalid_q;
    logic                       tlast_q;
    logic [CMD_STREAM_WIDTH-1:0] tdata_q;
    logic                       busy_q;
    logic                       err_q;
    logic                       load_en;
    logic                       req_fire;
    logic                       op_known;
    logic                       pay_fire;
    logic                       last_load;
`ifdef CMD_ENCODER_TEX16_PACK_EN
    logic                       half_q;
    logic [15:0]                lo_q;
`endif

    // The output register can take a new word when empty or draining this cycle.
    assign load_en   = !tvalid_q || m_cmd_axis_tready;
    assign req_fire  = s_req_ready && s_req_valid;
    assign op_known  = (s_req_op <= OP_TRIANGLE);
    assign last_load = (load_cnt_q == COUNTER_WIDTH'(1));

    assign s_req_ready           = (state_q == S_IDLE) && !reset;
    assign s_payload_axis_tready = (state_q == S_PAYLOAD) && load_en && (load_cnt_q != '0);
    assign pay_fire              = s_payload_axis_tready && s_payload_axis_tvalid;

    assign m_cmd_axis_tvalid = tvalid_q;
    assign m_cmd_axis_tlast  = tlast_q;
    assign m_cmd_axis_tdata  = tdata_q;
    assign busy              = busy_q;
    assign err_bad_op        = err_q;
    assign dbg_state         = state_q;

    always_comb begin
        word_cnt_d = '0;
        case (s_req_op)
            OP_TRIANGLE: word_cnt_d = COUNTER_WIDTH'(s_req_imm[15:2]);
            OP_TEXTURE: begin
                case (s_req_imm[3:0])
                    4'd1:    word_cnt_d = COUNTER_WIDTH'(512);
                    4'd2:    word_cnt_d = COUNTER_WIDTH'(2048);
                    4'd3:    word_cnt_d = COUNTER_WIDTH'(8192);
                    4'd4:    word_cnt_d = COUNTER_WIDTH'(32768);
                    default: word_cnt_d = '0;
                endcase
            end
            default: word_cnt_d = '0;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= OP_NOP;
            imm_q      <= '0;
            cfg_q      <= '0;
            load_cnt_q <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tdata_q    <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef CMD_ENCODER_TEX16_PACK_EN
            half_q     <= 1'b0;
            lo_q       <= '0;
`endif
        end else begin
            err_q <= req_fire && !op_known;
            if (tvalid_q && m_cmd_axis_tready) begin
                tvalid_q <= 1'b0;
                if (tlast_q) busy_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (req_fire && op_known) begin
                        op_q       <= s_req_op;
                        imm_q      <= s_req_imm;
                        cfg_q      <= s_req_cfg_data;
                        load_cnt_q <= word_cnt_d;
                        busy_q     <= 1'b1;
                        state_q    <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (load_en) begin
                        tvalid_q <= 1'b1;
                        tdata_q  <= {op_q, imm_q};
                        tlast_q  <= (load_cnt_q == '0) && (op_q != OP_RENDER);
                        if (load_cnt_q != '0)     state_q <= S_PAYLOAD;
                        else if (op_q == OP_RENDER) state_q <= S_CONFIG;
                        else                      state_q <= S_IDLE;
                    end
                end
                S_PAYLOAD: begin
                    if (pay_fire) begin
`ifdef CMD_ENCODER_TEX16_PACK_EN
                        // First beat parks in the low half; the second completes the word.
                        if (!half_q) begin
                            half_q <= 1'b1;
                            lo_q   <= s_payload_axis_tdata;
                        end else begin
                            half_q     <= 1'b0;
                            tvalid_q   <= 1'b1;
                            tdata_q    <= {s_payload_axis_tdata, lo_q};
                            tlast_q    <= last_load;
                            load_cnt_q <= load_cnt_q - COUNTER_WIDTH'(1);
                            if (last_load) state_q <= S_IDLE;
                        end
`else
                        tvalid_q   <= 1'b1;
                        tdata_q    <= s_payload_axis_tdata;
                        tlast_q    <= last_load;
                        load_cnt_q <= load_cnt_q - COUNTER_WIDTH'(1);
                        if (last_load) state_q <= S_IDLE;
`endif
                    end
                end
                S_CONFIG: begin
                    if (load_en) begin
                        tvalid_q <= 1'b1;
                        tdata_q  <= {16'h0000, cfg_q};
                        tlast_q  <= 1'b1;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_stream_encoder.sv
// Scoreboard bench for cmd_stream_encoder: stimulus pushes expected words, a monitor pops and compares.
module tb_cmd_stream_encoder;

    logic        aclk;
    logic        reset;
    logic        s_req_valid;
    logic        s_req_ready;
    logic [3:0]  s_req_op;
    logic [27:0] s_req_imm;
    logic [15:0] s_req_cfg_data;
    logic        s_payload_axis_tvalid;
    logic        s_payload_axis_tready;
    logic [31:0] s_payload_axis_tdata;
    logic        m_cmd_axis_tvalid;
    logic        m_cmd_axis_tready;
    logic        m_cmd_axis_tlast;
    logic [31:0] m_cmd_axis_tdata;
    logic        busy;
    logic        err_bad_op;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int beats_acc = 0;
    bit rnd_mode = 0;

    logic [32:0] exp_q[$];
    logic [31:0] pay_q[$];

    cmd_stream_encoder dut (
        .aclk                  (aclk),
        .reset                 (reset),
        .s_req_valid           (s_req_valid),
        .s_req_ready           (s_req_ready),
        .s_req_op              (s_req_op),
        .s_req_imm             (s_req_imm),
        .s_req_cfg_data        (s_req_cfg_data),
        .s_payload_axis_tvalid (s_payload_axis_tvalid),
        .s_payload_axis_tready (s_payload_axis_tready),
        .s_payload_axis_tdata  (s_payload_axis_tdata),
        .m_cmd_axis_tvalid     (m_cmd_axis_tvalid),
        .m_cmd_axis_tready     (m_cmd_axis_tready),
        .m_cmd_axis_tlast      (m_cmd_axis_tlast),
        .m_cmd_axis_tdata      (m_cmd_axis_tdata),
        .busy                  (busy),
        .err_bad_op            (err_bad_op),
        .dbg_state             (dbg_state)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Downstream ready: held high, or a coin flip per cycle when rnd_mode is set.
    initial begin
        m_cmd_axis_tready = 1'b0;
        forever begin
            @(posedge aclk); #1;
            m_cmd_axis_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Payload source: presents the head of pay_q, pops it after an accepted beat.
    initial begin
        bit fire;
        s_payload_axis_tvalid = 1'b0;
        s_payload_axis_tdata  = '0;
        forever begin
            @(negedge aclk);
            fire = s_payload_axis_tvalid && s_payload_axis_tready && !reset;
            @(posedge aclk); #1;
            if (fire && pay_q.size() > 0) begin
                void'(pay_q.pop_front());
                beats_acc++;
            end
            s_payload_axis_tvalid = (pay_q.size() > 0);
            s_payload_axis_tdata  = (pay_q.size() > 0) ? pay_q[0] : 32'h0;
        end
    end

    // Monitor: compare every handshaken word and check stability during stalls.
    initial begin
        bit          hold_v;
        logic [31:0] hold_d;
        logic        hold_l;
        logic [32:0] e;
        hold_v = 0;
        hold_d = '0;
        hold_l = 1'b0;
        forever begin
            @(negedge aclk);
            if (reset) begin
                hold_v = 0;
            end else begin
                if (hold_v) begin
                    chk("stall_tvalid", {31'h0, m_cmd_axis_tvalid}, 32'h1);
                    chk("stall_tdata", m_cmd_axis_tdata, hold_d);
                    chk("stall_tlast", {31'h0, m_cmd_axis_tlast}, {31'h0, hold_l});
                end
                hold_v = 0;
                if (m_cmd_axis_tvalid) begin
                    if (m_cmd_axis_tready) begin
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_word: got 0x%08h, required no word", m_cmd_axis_tdata);
                        end else begin
                            e = exp_q.pop_front();
                            chk("word_tdata", m_cmd_axis_tdata, e[31:0]);
                            chk("word_tlast", {31'h0, m_cmd_axis_tlast}, {31'h0, e[32]});
                        end
                    end else begin
                        hold_v = 1;
                        hold_d = m_cmd_axis_tdata;
                        hold_l = m_cmd_axis_tlast;
                    end
                end
            end
        end
    end

    task automatic send_req(input logic [3:0] op, input logic [27:0] imm, input logic [15:0] cfg);
        int t;
        @(posedge aclk); #1;
        s_req_valid    = 1'b1;
        s_req_op       = op;
        s_req_imm      = imm;
        s_req_cfg_data = cfg;
        t = 0;
        @(negedge aclk);
        while (!s_req_ready && t < 2000) begin
            @(negedge aclk);
            t++;
        end
        if (!s_req_ready) timeout_fail("req_accept");
        @(posedge aclk); #1;
        s_req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int t;
        t = 0;
        @(negedge aclk);
        while ((exp_q.size() != 0 || busy) && t < budget) begin
            @(negedge aclk);
            t++;
        end
        if (exp_q.size() != 0 || busy) timeout_fail(name);
    endtask

    initial begin
        int cyc;
        reset          = 1'b1;
        s_req_valid    = 1'b0;
        s_req_op       = '0;
        s_req_imm      = '0;
        s_req_cfg_data = '0;

        // Reset state
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("rst_tvalid", {31'h0, m_cmd_axis_tvalid}, 32'h0);
        chk("rst_tlast", {31'h0, m_cmd_axis_tlast}, 32'h0);
        chk("rst_tdata", m_cmd_axis_tdata, 32'h0);
        chk("rst_req_ready", {31'h0, s_req_ready}, 32'h0);
        chk("rst_pay_ready", {31'h0, s_payload_axis_tready}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_err", {31'h0, err_bad_op}, 32'h0);
        chk("rst_state", {29'h0, dbg_state}, 32'h0);
        @(posedge aclk); #1;
        reset = 1'b0;
        @(negedge aclk);
        chk("post_rst_req_ready", {31'h0, s_req_ready}, 32'h1);

        // FRAMEBUFFER header-only command, latency and busy timing
        exp_q.push_back({1'b1, 32'h3000_0031});
        send_req(4'd3, 28'h31, 16'h0);
        @(negedge aclk);
        chk("fb_busy_set", {31'h0, busy}, 32'h1);
        chk("fb_lat_cycle0", {31'h0, m_cmd_axis_tvalid}, 32'h0);
        @(negedge aclk);
        chk("fb_lat_cycle1", {31'h0, m_cmd_axis_tvalid}, 32'h1);
        @(negedge aclk);
        chk("fb_busy_clear", {31'h0, busy}, 32'h0);
        wait_done("fb_done", 100);

        // RENDER_CONFIG: header then config word
        exp_q.push_back({1'b0, 32'h2000_0002});
        exp_q.push_back({1'b1, 32'h0000_BEEF});
        send_req(4'd2, 28'h2, 16'hBEEF);
        wait_done("rc_done", 100);

        // TRIANGLE 48 bytes -> 12 words; a 13th queued beat must never be taken
        beats_acc = 0;
        exp_q.push_back({1'b0, 32'h4000_0030});
        for (int i = 0; i < 12; i++) exp_q.push_back({(i == 11), 32'(i)});
        for (int i = 0; i < 13; i++) pay_q.push_back(32'(i));
        send_req(4'd4, 28'h30, 16'h0);
        cyc = 0;
        do begin
            @(negedge aclk);
            cyc++;
        end while (!(m_cmd_axis_tvalid && m_cmd_axis_tready && m_cmd_axis_tlast) && cyc < 200);
        chk("tri_span_cycles", 32'(cyc), 32'd14);
        wait_done("tri_done", 100);
        repeat (4) @(negedge aclk);
        chk("tri_beats_accepted", 32'(beats_acc), 32'd12);
        chk("tri_pay_left", 32'(pay_q.size()), 32'd1);
        pay_q.delete();
        repeat (2) @(negedge aclk);

        // TEXTURE 32x32 with random backpressure: 513 words
        beats_acc = 0;
        rnd_mode  = 1;
        exp_q.push_back({1'b0, 32'h1000_0001});
        for (int i = 0; i < 512; i++) begin
            exp_q.push_back({(i == 511), 32'hC000_0000 | 32'(i)});
            pay_q.push_back(32'hC000_0000 | 32'(i));
        end
        send_req(4'd1, 28'h1, 16'h0);
        wait_done("tex_done", 10000);
        rnd_mode = 0;
        chk("tex_beats_accepted", 32'(beats_acc), 32'd512);

        // Unknown opcode, then NOP
        send_req(4'hF, 28'h0, 16'h0);
        @(negedge aclk);
        chk("badop_pulse", {31'h0, err_bad_op}, 32'h1);
        chk("badop_state", {29'h0, dbg_state}, 32'h0);
        chk("badop_busy", {31'h0, busy}, 32'h0);
        @(negedge aclk);
        chk("badop_pulse_end", {31'h0, err_bad_op}, 32'h0);
        exp_q.push_back({1'b1, 32'h0000_0000});
        send_req(4'd0, 28'h0, 16'h0);
        wait_done("nop_done", 100);

        // TEXTURE 64x64 cut by reset after payload word 100 is emitted
        exp_q.push_back({1'b0, 32'h1000_0002});
        for (int i = 0; i < 2048; i++) begin
            exp_q.push_back({(i == 2047), 32'hD000_0000 | 32'(i)});
            pay_q.push_back(32'hD000_0000 | 32'(i));
        end
        send_req(4'd1, 28'h2, 16'h0);
        cyc = 0;
        while (exp_q.size() > 1948 && cyc < 1000) begin
            @(negedge aclk);
            cyc++;
        end
        if (exp_q.size() > 1948) timeout_fail("rst_mid_reach");
        @(posedge aclk); #1;
        reset = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        chk("midrst_tvalid", {31'h0, m_cmd_axis_tvalid}, 32'h0);
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_pay_ready", {31'h0, s_payload_axis_tready}, 32'h0);
        exp_q.delete();
        pay_q.delete();
        @(posedge aclk); #1;
        reset = 1'b0;
        exp_q.push_back({1'b1, 32'h3000_0055});
        send_req(4'd3, 28'h55, 16'h0);
        wait_done("fb2_done", 100);
        repeat (3) @(negedge aclk);
        chk("end_state", {29'h0, dbg_state}, 32'h0);
        chk("end_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
